mcs4_pc_stack: RTL and testbench
================================

// Module: mcs4_pc_stack
// PURPOSE
//   Parametrised program counter and return-address stack for the MCS-4 CPU core family.
//   Holds the active PC as the top stack entry and applies one control-flow op per cycle:
//   INC, JUMP, JUMP_PAGE, CALL, RET. Depth and overflow policy are parametrised so the same block
//   serves a 4004-class core (4 entries) and a 4040-class core (8 entries).
//   Also provides a latched, nibble-serial address for the A1..A3 bus cycles.
// PARAMETERS
//   ADDR_W     12  PC width in bits; multiple of 4, range 12..16
//   DEPTH      4   stack entries including the active PC; power of 2, range 2..16
//   WRAP_MODE  1   1: pointer wraps on over/underflow (4004 behaviour); 0: op rejected, executes as INC
// PORTS
//   clk         in   1                 clock
//   rst         in   1                 synchronous, active-high reset
//   op_valid    in   1                 apply op this cycle
//   op          in   mcs4::pc_op_t     HOLD/INC/JUMP/JUMP_PAGE/CALL/RET
//   inc2        in   1                 instruction is double-word; increment is 2 instead of 1
//   target      in   ADDR_W            jump/call destination; JUMP_PAGE uses target[7:0] only
//   addr_latch  in   1                 capture the current pc into addr_buf
//   nib_sel     in   $clog2(ADDR_W/4)  nibble index for addr_nib; 0 = least significant
//   pc          out  ADDR_W            active PC = stack[sp]
//   addr_nib    out  4                 addr_buf[4*nib_sel +: 4], combinational
//   sp          out  $clog2(DEPTH)     stack pointer
//   ovf         out  1                 sticky; CALL issued at sp == DEPTH-1
//   unf         out  1                 sticky; RET issued at sp == 0
//   clr_flags   in   1                 clears ovf and unf
// BEHAVIOUR
//   Reset: sp=0, all stack entries 0, addr_buf=0, ovf=unf=0. So pc=0 and addr_nib=0 in the cycle after rst.
//   inc_pc = (pc + (inc2 ? 2 : 1)) mod 2^ADDR_W.
//   Ops take effect at the clock edge, 1-cycle latency. The new pc is visible the next cycle.
//   - op_valid=0 or op=HOLD: no state change.
//   - INC: stack[sp] <= inc_pc.
//   - JUMP: stack[sp] <= target.
//   - JUMP_PAGE: stack[sp] <= {inc_pc[ADDR_W-1:8], target[7:0]}.
//     The page comes from inc_pc, not pc, so a jump from the last byte(s) of a page lands in the next page.
//   - CALL: stack[sp] <= inc_pc (return address); stack[sp+1] <= target; sp <= sp+1.
//   - RET: sp <= sp-1. The new pc is the previously saved return address; stack[old sp] is left unchanged.
//   Overflow (CALL at sp==DEPTH-1): set ovf.
//     WRAP_MODE=1: sp wraps to 0, stack[0] <= target, and the oldest entry is lost.
//     WRAP_MODE=0: sp is unchanged and the op executes as INC.
//   Underflow (RET at sp==0): set unf.
//     WRAP_MODE=1: sp <= DEPTH-1.
//     WRAP_MODE=0: sp is unchanged and the op executes as INC.
//   PC arithmetic wraps modulo 2^ADDR_W with no flag; 12'hFFF + 1 = 12'h000.
//   addr_latch in the same cycle as an op: addr_buf captures the pre-op pc.
//   clr_flags in the same cycle as a new over/underflow: the set wins.
//   rst mid-sequence: all state returns to reset values on that edge, and any op in that cycle is discarded.
//   Op encoding outside the enum behaves as HOLD.
// STRUCTURE
//   mcs4 package: pc_op_t enum {PC_HOLD, PC_INC, PC_JUMP, PC_JUMP_PAGE, PC_CALL, PC_RET},
//     Page_bits = 8 constant, Max_stack_depth = 16.
//   Sub-module mcs4_addr_incr (ADDR_W):
//     inputs addr and inc2; outputs inc_pc and a page_cross flag (inc_pc page != addr page).
//     Carry-lookahead per nibble.
//   Stack storage: flat register array; no RAM inference is required.
// TESTING
//   1. Reset, then 5x INC -> pc=0x005; INC with inc2=1 from 0x0FE -> 0x100.
//   2. pc=0x2FF, JUMP_PAGE target=0x12 -> pc=0x312; pc=0x2F0, same op -> 0x212.
//   3. pc=0x010, CALL 0x400 -> sp=1, pc=0x400; RET -> sp=0, pc=0x011; CALL with inc2=1 -> return address is 0x012.
//   4. DEPTH=4, WRAP_MODE=1: 4 CALLs to 0x100,0x200,0x300,0x400 -> sp=0, pc=0x400, ovf=1;
//      RET from sp=0 -> sp=3, unf=1.
//   5. WRAP_MODE=0: CALL at sp=3 from pc=0x050 -> sp=3, pc=0x051, ovf=1;
//      clr_flags -> ovf=0; RET at sp=0 executes as INC and sets unf=1.
//   6. pc=0xABC, addr_latch together with JUMP 0x123 -> nib_sel 0/1/2 gives C/B/A and pc=0x123;
//      rst asserted during CALL -> sp=0, pc=0.

Source files
------------

// File: rtl/mcs4_pc_stack_pkg.sv
// mcs4_pc_stack_pkg: shared op encoding and constants for the MCS-4 PC/stack block
package mcs4_pc_stack_pkg;
  localparam int Page_bits = 8;
  localparam int Max_stack_depth = 16;
  typedef enum logic [2:0] {
    PC_HOLD,
    PC_INC,
    PC_JUMP,
    PC_JUMP_PAGE,
    PC_CALL,
    PC_RET
  } pc_op_t;
endpackage

// File: rtl/mcs4_addr_incr.sv
// mcs4_addr_incr: +1/+2 address incrementer with per-nibble lookahead carry and page-cross flag
module mcs4_addr_incr
  import mcs4_pc_stack_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              inc2_i,
  output logic [ADDR_W-1:0] inc_pc_o,
  output logic              page_cross_o
);
  localparam int N = ADDR_W / 4;
  logic [4:0] s0;
  assign s0 = {1'b0, addr_i[3:0]} + (inc2_i ? 5'd2 : 5'd1);
  assign inc_pc_o[3:0] = s0[3:0];
  for (genvar k = 1; k < N; k++) begin : g_nib
    logic cin;
    if (k == 1) begin : g_first
      assign cin = s0[4];
    end else begin : g_look
      assign cin = s0[4] & (&addr_i[4*k-1:4]);
    end
    assign inc_pc_o[4*k +: 4] = addr_i[4*k +: 4] + {3'b000, cin};
  end
  assign page_cross_o = inc_pc_o[ADDR_W-1:Page_bits] != addr_i[ADDR_W-1:Page_bits];
endmodule

// File: rtl/mcs4_pc_stack.sv
// mcs4_pc_stack: program counter with return-address stack and nibble-serial address latch
module mcs4_pc_stack
  import mcs4_pc_stack_pkg::*;
#(
  parameter int ADDR_W    = 12,
  parameter int DEPTH     = 4,
  parameter bit WRAP_MODE = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          op_valid_i,
  input  pc_op_t                        op_i,
  input  logic                          inc2_i,
  input  logic [ADDR_W-1:0]             target_i,
  input  logic                          addr_latch_i,
  input  logic [$clog2(ADDR_W/4)-1:0]   nib_sel_i,
  input  logic                          clr_flags_i,
  output logic [ADDR_W-1:0]             pc_o,
  output logic [3:0]                    addr_nib_o,
  output logic [$clog2(DEPTH)-1:0]      sp_o,
  output logic                          ovf_o,
  output logic                          unf_o
);
  localparam int SW = $clog2(DEPTH);
  if (DEPTH > Max_stack_depth || DEPTH < 2) begin : g_bad_depth
    $error("mcs4_pc_stack: DEPTH out of range");
  end
  logic [ADDR_W-1:0] stack_q [DEPTH];
  logic [SW-1:0]     sp_q, sp_d;
  logic [ADDR_W-1:0] buf_q, inc_pc, cur_d;
  logic              ovf_q, unf_q, page_cross, call_ovf, ret_unf, wr_cur, wr_nxt;
  pc_op_t            eff;
  mcs4_addr_incr #(.ADDR_W(ADDR_W)) u_incr (
    .addr_i      (pc_o),
    .inc2_i      (inc2_i),
    .inc_pc_o    (inc_pc),
    .page_cross_o(page_cross)
  );
  assign pc_o       = stack_q[sp_q];
  assign sp_o       = sp_q;
  assign ovf_o      = ovf_q;
  assign unf_o      = unf_q;
  assign addr_nib_o = 4'(buf_q >> {nib_sel_i, 2'b00});
  // Resolve the op actually executed; rejected over/underflows degrade to INC, unknown codes hold
  always_comb begin
    call_ovf = op_valid_i && op_i == PC_CALL && sp_q == SW'(DEPTH - 1);
    ret_unf  = op_valid_i && op_i == PC_RET && sp_q == '0;
    eff      = !op_valid_i ? PC_HOLD : (!WRAP_MODE && (call_ovf || ret_unf)) ? PC_INC : op_i;
    cur_d    = eff == PC_JUMP ? target_i :
               eff == PC_JUMP_PAGE ? {(page_cross ? inc_pc[ADDR_W-1:Page_bits] : pc_o[ADDR_W-1:Page_bits]),
                                      target_i[Page_bits-1:0]} : inc_pc;
    wr_cur   = eff inside {PC_INC, PC_JUMP, PC_JUMP_PAGE, PC_CALL};
    wr_nxt   = eff == PC_CALL;
    sp_d     = eff == PC_CALL ? sp_q + 1'b1 : eff == PC_RET ? sp_q - 1'b1 : sp_q;
  end
  // Stack, pointer, address latch and sticky flags; reset discards any same-cycle op
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stack_q[i] <= '0;
      sp_q  <= '0;
      buf_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (wr_cur) stack_q[sp_q] <= cur_d;
      if (wr_nxt) stack_q[sp_d] <= target_i;
      if (addr_latch_i) buf_q <= pc_o;
      sp_q  <= sp_d;
      ovf_q <= call_ovf | (ovf_q & ~clr_flags_i);
      unf_q <= ret_unf | (unf_q & ~clr_flags_i);
    end
  end
endmodule

// File: tb/tb_mcs4_pc_stack.sv
// tb_mcs4_pc_stack: wrap and no-wrap instances checked every cycle against a behavioural model
module tb_mcs4_pc_stack;
  import mcs4_pc_stack_pkg::*;
  logic clk = 1'b0, rst = 1'b0, op_valid = 1'b0, inc2 = 1'b0, addr_latch = 1'b0, clr_flags = 1'b0;
  pc_op_t op = PC_HOLD;
  logic [11:0] target = '0;
  logic [1:0] nib_sel = '0;
  logic [11:0] pc1, pc0;
  logic [1:0] sp1, sp0;
  logic [3:0] nib1, nib0;
  logic ovf1, ovf0, unf1, unf0;
  int n_checks = 0, n_fail = 0;
  bit chk_en = 1'b0;
  int m_stk[2][4];
  int m_sp[2];
  int m_buf[2];
  bit m_ovf[2], m_unf[2];

  always #5 clk = ~clk;

  mcs4_pc_stack #(.ADDR_W(12), .DEPTH(4), .WRAP_MODE(1'b1)) u_dut (
    .clk(clk), .rst(rst), .op_valid_i(op_valid), .op_i(op), .inc2_i(inc2), .target_i(target),
    .addr_latch_i(addr_latch), .nib_sel_i(nib_sel), .clr_flags_i(clr_flags),
    .pc_o(pc1), .addr_nib_o(nib1), .sp_o(sp1), .ovf_o(ovf1), .unf_o(unf1)
  );
  mcs4_pc_stack #(.ADDR_W(12), .DEPTH(4), .WRAP_MODE(1'b0)) u_dut_nowrap (
    .clk(clk), .rst(rst), .op_valid_i(op_valid), .op_i(op), .inc2_i(inc2), .target_i(target),
    .addr_latch_i(addr_latch), .nib_sel_i(nib_sel), .clr_flags_i(clr_flags),
    .pc_o(pc0), .addr_nib_o(nib0), .sp_o(sp0), .ovf_o(ovf0), .unf_o(unf0)
  );

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: w=1 wraps the pointer on over/underflow, w=0 rejects and increments instead
  task automatic model_tick();
    for (int w = 0; w < 2; w++) begin
      if (rst) begin
        for (int i = 0; i < 4; i++) m_stk[w][i] = 0;
        m_sp[w] = 0; m_buf[w] = 0; m_ovf[w] = 0; m_unf[w] = 0;
      end else begin
        int sp, pc, nx;
        sp = m_sp[w];
        pc = m_stk[w][sp];
        nx = (pc + (inc2 ? 2 : 1)) % 4096;
        if (addr_latch) m_buf[w] = pc;
        if (clr_flags) begin m_ovf[w] = 0; m_unf[w] = 0; end
        if (op_valid) begin
          case (op)
            PC_INC:       m_stk[w][sp] = nx;
            PC_JUMP:      m_stk[w][sp] = int'(target);
            PC_JUMP_PAGE: m_stk[w][sp] = (nx / 256) * 256 + int'(target) % 256;
            PC_CALL: begin
              m_stk[w][sp] = nx;
              if (sp == 3) begin
                m_ovf[w] = 1;
                if (w == 1) begin m_sp[w] = 0; m_stk[w][0] = int'(target); end
              end else begin
                m_sp[w] = sp + 1;
                m_stk[w][sp + 1] = int'(target);
              end
            end
            PC_RET: begin
              if (sp == 0) begin
                m_unf[w] = 1;
                if (w == 1) m_sp[w] = 3;
                else m_stk[w][0] = nx;
              end else m_sp[w] = sp - 1;
            end
            default: ;
          endcase
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("wrap.pc", pc1, m_stk[1][m_sp[1]]);
      chk("wrap.sp", sp1, m_sp[1]);
      chk("wrap.ovf", ovf1, m_ovf[1]);
      chk("wrap.unf", unf1, m_unf[1]);
      chk("wrap.nib", nib1, (m_buf[1] >> (4 * nib_sel)) & 15);
      chk("nowrap.pc", pc0, m_stk[0][m_sp[0]]);
      chk("nowrap.sp", sp0, m_sp[0]);
      chk("nowrap.ovf", ovf0, m_ovf[0]);
      chk("nowrap.unf", unf0, m_unf[0]);
      chk("nowrap.nib", nib0, (m_buf[0] >> (4 * nib_sel)) & 15);
    end
  end

  task automatic tick();
    @(posedge clk);
    model_tick();
    #1;
  endtask

  task automatic do_op(pc_op_t o, logic [11:0] t = '0, logic i2 = 1'b0, logic lat = 1'b0,
                       logic clr = 1'b0, logic [1:0] ns = '0);
    rst = 1'b0; op_valid = 1'b1; op = o; target = t; inc2 = i2;
    addr_latch = lat; clr_flags = clr; nib_sel = ns;
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1; op_valid = 1'b1; op = PC_CALL; target = 12'h777;
    inc2 = 1'b0; addr_latch = 1'b1; clr_flags = 1'b0; nib_sel = '0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    do_reset();
    chk_en = 1'b1;
    chk("reset pc", pc1, 32'h0);
    chk("reset sp", sp1, 32'h0);
    chk("reset nib", nib1, 32'h0);
    repeat (5) do_op(PC_INC);
    chk("5x inc", pc1, 32'h005);
    do_op(PC_JUMP, 12'h0FE);
    do_op(PC_INC, 12'h0, 1'b1);
    chk("inc2 0x0FE", pc1, 32'h100);
    do_op(PC_JUMP, 12'h2FF);
    do_op(PC_JUMP_PAGE, 12'h012);
    chk("jump_page cross", pc1, 32'h312);
    do_op(PC_JUMP, 12'h2F0);
    do_op(PC_JUMP_PAGE, 12'h012);
    chk("jump_page same", pc1, 32'h212);
    do_op(PC_JUMP, 12'h010);
    do_op(PC_CALL, 12'h400);
    chk("call sp", sp1, 32'h1);
    chk("call pc", pc1, 32'h400);
    do_op(PC_RET);
    chk("ret sp", sp1, 32'h0);
    chk("ret pc", pc1, 32'h011);
    do_op(PC_JUMP, 12'h010);
    do_op(PC_CALL, 12'h500, 1'b1);
    do_op(PC_RET);
    chk("call inc2 ret", pc1, 32'h012);

    do_reset();
    do_op(PC_CALL, 12'h100);
    do_op(PC_CALL, 12'h200);
    do_op(PC_CALL, 12'h300);
    do_op(PC_CALL, 12'h400);
    chk("wrap ovf sp", sp1, 32'h0);
    chk("wrap ovf pc", pc1, 32'h400);
    chk("wrap ovf flag", ovf1, 32'h1);
    chk("nowrap ovf sp", sp0, 32'h3);
    chk("nowrap ovf pc", pc0, 32'h301);
    do_op(PC_RET);
    chk("wrap unf sp", sp1, 32'h3);
    chk("wrap unf flag", unf1, 32'h1);
    chk("nowrap ret sp", sp0, 32'h2);

    do_reset();
    do_op(PC_CALL, 12'h010);
    do_op(PC_CALL, 12'h020);
    do_op(PC_CALL, 12'h030);
    do_op(PC_JUMP, 12'h050);
    do_op(PC_CALL, 12'h999);
    chk("nowrap reject sp", sp0, 32'h3);
    chk("nowrap reject pc", pc0, 32'h051);
    chk("nowrap reject ovf", ovf0, 32'h1);
    do_op(PC_HOLD, 12'h0, 1'b0, 1'b0, 1'b1);
    chk("clr ovf", ovf0, 32'h0);
    repeat (3) do_op(PC_RET);
    do_op(PC_RET, 12'h0, 1'b0, 1'b0, 1'b1);
    chk("nowrap unf flag", unf0, 32'h1);
    chk("nowrap unf sp", sp0, 32'h0);
    chk("nowrap unf pc", pc0, 32'h002);

    do_op(PC_JUMP, 12'hABC);
    do_op(PC_JUMP, 12'h123, 1'b0, 1'b1);
    chk("latch+jump pc", pc1, 32'h123);
    do_op(PC_HOLD, 12'h0, 1'b0, 1'b0, 1'b0, 2'd0);
    chk("nib0", nib1, 32'hC);
    do_op(PC_HOLD, 12'h0, 1'b0, 1'b0, 1'b0, 2'd1);
    chk("nib1", nib1, 32'hB);
    do_op(PC_HOLD, 12'h0, 1'b0, 1'b0, 1'b0, 2'd2);
    chk("nib2", nib1, 32'hA);
    do_op(pc_op_t'(3'd7), 12'h555);
    chk("bad op holds", pc1, 32'h123);
    do_op(PC_CALL, 12'h321);
    do_reset();
    chk("rst during call sp", sp1, 32'h0);
    chk("rst during call pc", pc1, 32'h0);

    repeat (3000) begin
      rst        = $urandom_range(0, 99) == 0;
      op_valid   = $urandom_range(0, 7) != 0;
      op         = pc_op_t'(3'($urandom_range(0, 7)));
      target     = 12'($urandom);
      if ($urandom_range(0, 3) == 0) target[7:0] = 8'hFE | 8'($urandom_range(0, 1));
      inc2       = 1'($urandom_range(0, 1));
      addr_latch = $urandom_range(0, 3) == 0;
      clr_flags  = $urandom_range(0, 15) == 0;
      nib_sel    = 2'($urandom_range(0, 2));
      tick();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
